// File: rtl/move_query_arbiter.sv
// move_query_arbiter: shares one combinational maze lookup (valid_moves)
// between Pac-Man (requester 0) and the ghosts (requesters 1..NUM_REQ-1).
// A Start tick snapshots every sprite position. Each enabled requester is
// then presented to the lookup in turn, and its 4-bit direction result is
// captured into a per-requester table.
// Optional build macro: MOVE_ARB_OVERRUN_EN. When it is defined, a Start
// that arrives while Busy is high sets the sticky Overrun flag.
// Query address timing: the address registers load on the clock edge that
// enters an index. The lookup result is sampled on the edge that leaves
// CAPTURE. Each enabled index therefore costs SETTLE+1 cycles. With
// SETTLE=0 an enabled index goes straight into CAPTURE.
module move_query_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int SETTLE  = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [NUM_REQ-1:0]      Req_En,
  input  logic [10*NUM_REQ-1:0]   Pos_X_In,
  input  logic [10*NUM_REQ-1:0]   Pos_Y_In,
  output logic [9:0]              Query_X,
  output logic [9:0]              Query_Y,
  output logic                    Query_Is_Ghost,
  input  logic [3:0]              Query_Dir,
  output logic [4*NUM_REQ-1:0]    Dir_Out,
  output logic [NUM_REQ-1:0]      Dir_Valid,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Overrun
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam bit NO_SETTLE = (SETTLE == 0);

  typedef enum logic [1:0] {IDLE, SCAN, CAPTURE, DONE} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [3:0]              settle_cnt;
  logic [10*NUM_REQ-1:0]   snap_x;
  logic [10*NUM_REQ-1:0]   snap_y;
  logic [NUM_REQ-1:0]      snap_en;
  logic [9:0]              qx_reg;
  logic [9:0]              qy_reg;
  logic                    qg_reg;
  logic [NUM_REQ-1:0]      valid_reg;
  logic                    busy_reg;
  logic                    done_reg;

  // Signals that describe how the FSM moves on from the current index.
  logic                    is_last;
  logic [IW-1:0]           adv_idx;
  logic                    adv_en;
  logic [9:0]              adv_x;
  logic [9:0]              adv_y;
  state_t                  adv_state;

  // Work out the next index, its snapshot, and the state that follows it.
  // The index saturates at the last requester, so every snapshot select
  // stays in range.
  always_comb begin
    is_last   = (idx == LAST_IDX);
    adv_idx   = is_last ? idx : idx + 1'b1;
    adv_en    = snap_en[adv_idx];
    adv_x     = snap_x[adv_idx*10 +: 10];
    adv_y     = snap_y[adv_idx*10 +: 10];
    adv_state = SCAN;
    if (is_last)
      adv_state = DONE;
    else if (NO_SETTLE && adv_en)
      adv_state = CAPTURE;
  end

  // Main sweep FSM. All outputs are registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_en    <= '0;
      qx_reg     <= '0;
      qy_reg     <= '0;
      qg_reg     <= 1'b0;
      valid_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            snap_x     <= Pos_X_In;
            snap_y     <= Pos_Y_In;
            snap_en    <= Req_En;
            valid_reg  <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            busy_reg   <= 1'b1;
            // Requester 0 is presented straight from the live inputs,
            // because they are being snapshotted on this same edge.
            if (Req_En[0]) begin
              qx_reg <= Pos_X_In[9:0];
              qy_reg <= Pos_Y_In[9:0];
              qg_reg <= 1'b0;
            end
            state <= (NO_SETTLE && Req_En[0]) ? CAPTURE : SCAN;
          end
        end
        SCAN: begin
          if (!snap_en[idx]) begin
            // A disabled requester is skipped in one cycle. Its table entry
            // is left untouched.
            state <= adv_state;
            idx   <= adv_idx;
            if (!is_last && adv_en) begin
              qx_reg <= adv_x;
              qy_reg <= adv_y;
              qg_reg <= 1'b1;
            end
            if (is_last) done_reg <= 1'b1;
          end else if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAPTURE: begin
          valid_reg[idx] <= 1'b1;
          state          <= adv_state;
          idx            <= adv_idx;
          if (!is_last && adv_en) begin
            qx_reg <= adv_x;
            qy_reg <= adv_y;
            qg_reg <= 1'b1;
          end
          if (is_last) done_reg <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-requester direction table, written while that index is in CAPTURE.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dir
      logic [3:0] dir_reg;

      // Capture the lookup result for requester gi.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
          dir_reg <= 4'h0;
        else if (state == CAPTURE && idx == IW'(gi))
          dir_reg <= Query_Dir;
      end

      assign Dir_Out[4*gi +: 4] = dir_reg;
    end
  endgenerate

`ifdef MOVE_ARB_OVERRUN_EN
  logic overrun_reg;

  // Sticky flag: a Start was dropped because a sweep was still running.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      overrun_reg <= 1'b0;
    else if (Start && busy_reg)
      overrun_reg <= 1'b1;
  end

  assign Overrun = overrun_reg;
`else
  assign Overrun = 1'b0;
`endif

  assign Query_X        = qx_reg;
  assign Query_Y        = qy_reg;
  assign Query_Is_Ghost = qg_reg;
  assign Dir_Valid      = valid_reg;
  assign Busy           = busy_reg;
  assign Done           = done_reg;

endmodule

// File: tb/tb_move_query_arbiter.sv
// tb_move_query_arbiter: directed bench for move_query_arbiter. It drives a
// SETTLE=1 instance and a SETTLE=0 instance. The lookup model maps Query_Y
// to a direction nibble.
module tb_move_query_arbiter;

`ifdef MOVE_ARB_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Start0;
  logic [4:0]  Req_En;
  logic [49:0] Pos_X_In;
  logic [49:0] Pos_Y_In;

  logic [9:0]  qx, qy, qx0, qy0;
  logic        ghost, ghost0;
  logic [3:0]  qdir, qdir0;
  logic [19:0] dir_out, dir_out0;
  logic [4:0]  dvalid, dvalid0;
  logic        busy, busy0, done, done0, ovr, ovr0;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  // Lookup model: rows 0..4 give 1,2,4,8,F and rows 5..9 give 3,6,C,9,5.
  function automatic logic [3:0] lut(input logic [9:0] y);
    case (y)
      10'd0: lut = 4'h1;
      10'd1: lut = 4'h2;
      10'd2: lut = 4'h4;
      10'd3: lut = 4'h8;
      10'd4: lut = 4'hF;
      10'd5: lut = 4'h3;
      10'd6: lut = 4'h6;
      10'd7: lut = 4'hC;
      10'd8: lut = 4'h9;
      10'd9: lut = 4'h5;
      default: lut = 4'h0;
    endcase
  endfunction

  assign qdir  = lut(qy);
  assign qdir0 = lut(qy0);

  move_query_arbiter #(.NUM_REQ(5), .SETTLE(1)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Req_En(Req_En),
    .Pos_X_In(Pos_X_In), .Pos_Y_In(Pos_Y_In),
    .Query_X(qx), .Query_Y(qy), .Query_Is_Ghost(ghost), .Query_Dir(qdir),
    .Dir_Out(dir_out), .Dir_Valid(dvalid), .Busy(busy), .Done(done),
    .Overrun(ovr)
  );

  move_query_arbiter #(.NUM_REQ(5), .SETTLE(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start0), .Req_En(Req_En),
    .Pos_X_In(Pos_X_In), .Pos_Y_In(Pos_Y_In),
    .Query_X(qx0), .Query_Y(qy0), .Query_Is_Ghost(ghost0), .Query_Dir(qdir0),
    .Dir_Out(dir_out0), .Dir_Valid(dvalid0), .Busy(busy0), .Done(done0),
    .Overrun(ovr0)
  );

  // X positions are 40,60,80,100,120. Y is row_base+i.
  task automatic set_pos(input int row_base);
    for (int i = 0; i < 5; i++) begin
      Pos_X_In[10*i +: 10] = 10'(40 + 20*i);
      Pos_Y_In[10*i +: 10] = 10'(row_base + i);
    end
  endtask

  // Pulse Start for one cycle (cycle 0). Returns at the negedge of cycle 1.
  task automatic kick(input logic [4:0] en, input bit use0);
    @(negedge Clk);
    Req_En = en;
    if (use0) Start0 = 1'b1;
    else      Start  = 1'b1;
    @(negedge Clk);
    Start  = 1'b0;
    Start0 = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Start0 = 1'b0; Req_En = '0;
    set_pos(0);
    #3;
    tests++; if ({qx, qy, ghost} !== 21'd0) begin fails++; $display("FAIL reset_query: got %h/%h/%b want 0", qx, qy, ghost); end
    tests++; if (dir_out !== 20'h0 || dvalid !== 5'h0) begin fails++; $display("FAIL reset_table: got %h/%b want 0", dir_out, dvalid); end
    tests++; if ({busy, done, ovr} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, done, ovr}); end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_all_enabled();
    int done_at = -1;
    set_pos(0);
    kick(5'b11111, 0);
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      if (c > 1) @(negedge Clk);
      if (done) done_at = c;
      if (c <= 10) begin
        tests++; if (ghost !== (c > 2)) begin fails++; $display("FAIL ghost_c%0d: got %b want %b", c, ghost, (c > 2)); end
        tests++; if (qx !== 10'(40 + 20*((c-1)/2))) begin fails++; $display("FAIL query_x_c%0d: got %0d want %0d", c, qx, 40 + 20*((c-1)/2)); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_c%0d: got %b want 1", c, busy); end
      end
    end
    tests++; if (done_at != 11) begin fails++; $display("FAIL all_done_cycle: got %0d want 11", done_at); end
    tests++; if (dir_out !== 20'hF8421) begin fails++; $display("FAIL all_dir_out: got %h want F8421", dir_out); end
    tests++; if (dvalid !== 5'b11111) begin fails++; $display("FAIL all_dir_valid: got %b want 11111", dvalid); end
    @(negedge Clk);
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL all_idle_after: got busy/done %b want 00", {busy, done}); end
    $display("[TB] all_enabled: done at cycle %0d dir_out=%h", done_at, dir_out);
  endtask

  task automatic test_partial();
    int done_at = -1;
    set_pos(5);
    kick(5'b10101, 0);
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      if (c > 1) @(negedge Clk);
      if (done) done_at = c;
      if (c == 1) begin
        tests++; if (dvalid !== 5'b00000) begin fails++; $display("FAIL partial_valid_clear: got %b want 00000", dvalid); end
      end
      if (c == 3) begin
        tests++; if (qx !== 10'd40) begin fails++; $display("FAIL partial_skip_hold: got %0d want 40", qx); end
      end
    end
    tests++; if (done_at != 9) begin fails++; $display("FAIL partial_done_cycle: got %0d want 9", done_at); end
    tests++; if (dir_out !== 20'h58C23) begin fails++; $display("FAIL partial_dir_out: got %h want 58C23", dir_out); end
    tests++; if (dvalid !== 5'b10101) begin fails++; $display("FAIL partial_dir_valid: got %b want 10101", dvalid); end
    $display("[TB] partial: done at cycle %0d dir_out=%h", done_at, dir_out);
  endtask

  task automatic test_snapshot();
    int done_at = -1;
    set_pos(0);
    kick(5'b11111, 0);
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      if (c > 1) @(negedge Clk);
      if (done) done_at = c;
      if (c == 2) Pos_X_In[39:30] = 10'd200;
      if (c == 7 || c == 8) begin
        tests++; if (qx !== 10'd100) begin fails++; $display("FAIL snapshot_x_c%0d: got %0d want 100", c, qx); end
      end
    end
    tests++; if (done_at != 11) begin fails++; $display("FAIL snapshot_done_cycle: got %0d want 11", done_at); end
    set_pos(0);
    $display("[TB] snapshot: done at cycle %0d", done_at);
  endtask

  task automatic test_back_to_back();
    int done_at = -1;
    int n_done = 0;
    kick(5'b11111, 0);
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) @(negedge Clk);
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (c == 6) begin
        tests++; if (ovr !== EXP_OVR) begin fails++; $display("FAIL overrun_c6: got %b want %b", ovr, EXP_OVR); end
      end
      if (c == 5) Start = 1'b1;
      if (c == 6) Start = 1'b0;
    end
    tests++; if (n_done != 1 || done_at != 11) begin fails++; $display("FAIL restart_done: got %0d pulses first at %0d want 1 at 11", n_done, done_at); end
    tests++; if (ovr !== EXP_OVR) begin fails++; $display("FAIL overrun_sticky: got %b want %b", ovr, EXP_OVR); end
    $display("[TB] back_to_back: %0d done pulse(s), overrun=%b", n_done, ovr);
  endtask

  task automatic test_reset_mid();
    int done_at = -1;
    kick(5'b11111, 0);
    repeat (3) @(negedge Clk);  // now in cycle 4
    Reset = 1'b1;
    #1;
    tests++; if ({qx, qy, ghost} !== 21'd0) begin fails++; $display("FAIL midreset_query: got %h/%h/%b want 0", qx, qy, ghost); end
    tests++; if (dir_out !== 20'h0 || dvalid !== 5'h0) begin fails++; $display("FAIL midreset_table: got %h/%b want 0", dir_out, dvalid); end
    tests++; if ({busy, done, ovr} !== 3'b000) begin fails++; $display("FAIL midreset_flags: got %b want 000", {busy, done, ovr}); end
    @(negedge Clk);
    Reset = 1'b0;
    kick(5'b11111, 0);
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      if (c > 1) @(negedge Clk);
      if (done) done_at = c;
    end
    tests++; if (done_at != 11) begin fails++; $display("FAIL midreset_done_cycle: got %0d want 11", done_at); end
    tests++; if (dir_out !== 20'hF8421) begin fails++; $display("FAIL midreset_dir_out: got %h want F8421", dir_out); end
    $display("[TB] reset_mid: rerun done at cycle %0d", done_at);
  endtask

  task automatic test_all_disabled();
    int done_at = -1;
    kick(5'b00000, 0);
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      if (c > 1) @(negedge Clk);
      if (done) done_at = c;
    end
    tests++; if (done_at != 6) begin fails++; $display("FAIL disabled_done_cycle: got %0d want 6", done_at); end
    tests++; if (dvalid !== 5'b00000) begin fails++; $display("FAIL disabled_valid: got %b want 00000", dvalid); end
    tests++; if (dir_out !== 20'hF8421) begin fails++; $display("FAIL disabled_dir_kept: got %h want F8421", dir_out); end
    $display("[TB] all_disabled: done at cycle %0d", done_at);
  endtask

  task automatic test_settle0();
    int done_at = -1;
    set_pos(0);
    kick(5'b11111, 1);
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      if (c > 1) @(negedge Clk);
      if (done0) done_at = c;
      if (c <= 5) begin
        tests++; if (qx0 !== 10'(40 + 20*(c-1))) begin fails++; $display("FAIL settle0_x_c%0d: got %0d want %0d", c, qx0, 40 + 20*(c-1)); end
      end
    end
    tests++; if (done_at != 6) begin fails++; $display("FAIL settle0_done_cycle: got %0d want 6", done_at); end
    tests++; if (dir_out0 !== 20'hF8421) begin fails++; $display("FAIL settle0_dir_out: got %h want F8421", dir_out0); end
    $display("[TB] settle0: done at cycle %0d dir_out=%h", done_at, dir_out0);
  endtask

  initial begin
    test_reset();
    test_all_enabled();
    test_partial();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    test_all_disabled();
    test_settle0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
